uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx.sv | 139 +++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encodings (used by uart_tx and uart_rx).
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter, 16x oversampled, LSB first, configurable data/stop length.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

  uart_state_t     r_state, w_state_n;
  logic [4:0]      r_tick, w_tick_n;
  logic [2:0]      r_bit, w_bit_n;
  logic [DBIT-1:0] r_sreg, w_sreg_n;
  logic            r_tx, w_tx_n;
  logic            w_done;
  logic            w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic            r_par, w_par_n;
`endif

  assign w_bit_end = s_tick && (r_tick[3:0] == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_sreg  <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_tick  <= w_tick_n;
      r_bit   <= w_bit_n;
      r_sreg  <= w_sreg_n;
      r_tx    <= w_tx_n;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) r_par <= 1'b0;
    else       r_par <= w_par_n;
  end
`endif

  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_bit_n   = r_bit;
    w_sreg_n  = r_sreg;
    w_done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_n   = r_par;
`endif
    if (s_tick && (r_state != ST_IDLE))
      w_tick_n = r_tick + 5'd1;
    unique case (r_state)
      ST_IDLE: begin
        if (tx_start) begin
          w_state_n = ST_START;
          w_tick_n  = '0;
          w_bit_n   = '0;
          w_sreg_n  = din[DBIT-1:0];
`ifdef UART_TX_PARITY_EN
          w_par_n   = ^din[DBIT-1:0];
`endif
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_tick_n  = '0;
          w_state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_tick_n = '0;
          w_sreg_n = r_sreg >> 1;
          w_bit_n  = r_bit + 3'd1;
          if (r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_n = ST_PARITY;
`else
            w_state_n = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_tick_n  = '0;
          w_state_n = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // stop length may exceed one bit, so compare all 5 counter bits
        if (s_tick && (r_tick == STOP_LAST)) begin
          w_tick_n  = '0;
          w_state_n = ST_IDLE;
          w_done    = 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // line level follows the state being entered so tx stays registered
  always_comb begin
    w_tx_n = 1'b1;
    unique case (w_state_n)
      ST_START:  w_tx_n = 1'b0;
      ST_DATA:   w_tx_n = w_sreg_n[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_n = w_par_n;
`endif
      default:   w_tx_n = 1'b1;
    endcase
  end

  assign tx           = r_tx;
  assign tx_busy      = (r_state != ST_IDLE);
  assign tx_done_tick = w_done & ~reset;

endmodule
